// File: rtl/obi_addr_demux.sv
// 1-to-N OBI address demultiplexer with in-order response tracking.
// Unmapped addresses get an internal error response; a head entry that hangs is retired by timeout.
module obi_addr_demux #(
    parameter int unsigned NUM_SLAVES      = 5,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SEL_MSB         = 31,
    parameter int unsigned SEL_LSB         = 24,
    parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_IDS =
        {8'hF, 8'hE, 8'hA, 8'h2, 8'h0},
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            m_req_i,
    output logic                            m_gnt_o,
    input  logic [ADDR_WIDTH-1:0]           m_addr_i,
    input  logic                            m_we_i,
    input  logic [DATA_WIDTH/8-1:0]         m_be_i,
    input  logic [DATA_WIDTH-1:0]           m_wdata_i,
    output logic                            m_rvalid_o,
    output logic [DATA_WIDTH-1:0]           m_rdata_o,
    output logic                            m_err_o,
    output logic [NUM_SLAVES-1:0]           s_req_o,
    input  logic [NUM_SLAVES-1:0]           s_gnt_i,
    output logic [ADDR_WIDTH-1:0]           s_addr_o,
    output logic                            s_we_o,
    output logic [DATA_WIDTH/8-1:0]         s_be_o,
    output logic [DATA_WIDTH-1:0]           s_wdata_o,
    input  logic [NUM_SLAVES-1:0]           s_rvalid_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i
);

    localparam int unsigned SelW = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned TgtW = $clog2(NUM_SLAVES + 1);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TmrW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TgtW-1:0] ErrTgt = TgtW'(NUM_SLAVES);

    // All in-flight entries share one target, so the FIFO reduces to a count plus that target.
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TgtW-1:0] tgt_q, tgt_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic [CntW-1:0] drop_q [NUM_SLAVES];
    logic [CntW-1:0] drop_d [NUM_SLAVES];

    logic [TgtW-1:0]       target;
    logic                  tgt_is_err, s_gnt_sel, tgt_drop_zero, issue_ok, push;
    logic                  busy, head_err, head_rvalid, head_drop_zero;
    logic [DATA_WIDTH-1:0] head_rdata;
    logic                  real_resp, err_resp, timeout, pop;

    assign s_addr_o  = m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_wdata_o = m_wdata_i;

    always_comb begin
        // Descending scan so the lowest matching index wins.
        target = ErrTgt;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (m_addr_i[SEL_MSB:SEL_LSB] == SLAVE_IDS[i*SelW +: SelW]) target = TgtW'(i);
        end
    end

    always_comb begin
        s_gnt_sel      = 1'b0;
        tgt_drop_zero  = 1'b1;
        head_rvalid    = 1'b0;
        head_rdata     = '0;
        head_drop_zero = 1'b1;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (target == TgtW'(i)) begin
                s_gnt_sel     = s_gnt_i[i];
                tgt_drop_zero = (drop_q[i] == '0);
            end
            if (tgt_q == TgtW'(i)) begin
                head_rvalid    = s_rvalid_i[i];
                head_rdata     = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                head_drop_zero = (drop_q[i] == '0);
            end
        end
    end

    assign tgt_is_err = (target == ErrTgt);
    assign issue_ok   = rst_ni && (cnt_q != CntW'(MAX_OUTSTANDING)) &&
                        ((cnt_q == '0) || (tgt_q == target)) && tgt_drop_zero;
    assign m_gnt_o    = issue_ok && (tgt_is_err || s_gnt_sel);
    assign push       = m_req_i && m_gnt_o;

    always_comb begin
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            s_req_o[i] = m_req_i && issue_ok && (target == TgtW'(i));
        end
    end

    assign busy      = (cnt_q != '0);
    assign head_err  = (tgt_q == ErrTgt);
    assign real_resp = busy && !head_err && head_rvalid && head_drop_zero;
    assign err_resp  = busy && head_err;
    assign timeout   = (TIMEOUT_CYCLES != 0) && busy && !head_err && !real_resp &&
                       (timer_q == TmrW'(TIMEOUT_CYCLES));
    assign pop       = real_resp || err_resp || timeout;

    assign m_rvalid_o = pop;
    assign m_err_o    = err_resp || timeout;
    assign m_rdata_o  = real_resp ? head_rdata : (m_err_o ? ERR_RDATA : '0);

    always_comb begin
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        tgt_d = push ? target : tgt_q;
        // The push cycle counts as the first waiting cycle.
        if (pop || (!busy && !push)) timer_d = '0;
        else                         timer_d = timer_q + TmrW'(1);
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            logic inc, dec;
            inc = timeout && (tgt_q == TgtW'(i));
            dec = s_rvalid_i[i] && (drop_q[i] != '0);
            drop_d[i] = drop_q[i];
            if (inc && !dec && (drop_q[i] != CntW'(MAX_OUTSTANDING))) drop_d[i] = drop_q[i] + 1'b1;
            else if (dec && !inc)                                    drop_d[i] = drop_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            tgt_q   <= '0;
            timer_q <= '0;
            for (int i = 0; i < int'(NUM_SLAVES); i++) drop_q[i] <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            timer_q <= timer_d;
            for (int i = 0; i < int'(NUM_SLAVES); i++) drop_q[i] <= drop_d[i];
        end
    end

endmodule

// File: tb/tb_obi_addr_demux.sv
// Directed bench for obi_addr_demux: decode, error slave, ordering, timeout/drop, writes, reset.
module tb_obi_addr_demux;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        m_req;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [4:0]  s_req;
    logic [4:0]  s_gnt;
    logic [31:0] s_addr;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic [4:0]  s_rvalid;
    logic [31:0] rd [5];
    logic [159:0] s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    assign s_rdata = {rd[4], rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    obi_addr_demux #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req),
        .m_gnt_o    (m_gnt),
        .m_addr_i   (m_addr),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_wdata_i  (m_wdata),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .m_err_o    (m_err),
        .s_req_o    (s_req),
        .s_gnt_i    (s_gnt),
        .s_addr_o   (s_addr),
        .s_we_o     (s_we),
        .s_be_o     (s_be),
        .s_wdata_o  (s_wdata),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata)
    );

    task automatic idle_inputs();
        m_req = 0; m_addr = '0; m_we = 0; m_be = 4'hF; m_wdata = '0;
        s_gnt = '0; s_rvalid = '0;
        for (int i = 0; i < 5; i++) rd[i] = '0;
    endtask

    // Advance to just after the next rising edge; stimulus is applied here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        idle_inputs();
        #2;
        n_checks++; if (m_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", m_gnt); end
        n_checks++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", m_rvalid); end
        n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        n_checks++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", m_err); end
        n_checks++; if (s_req !== 5'b0) begin n_fail++; $display("FAIL reset_sreq: got %b want 0", s_req); end
        next_cycle(); next_cycle();
        #2 rst_ni = 1;
        next_cycle();
    endtask

    task automatic test_read_slave0();
        m_req = 1; m_addr = 32'h0000_0010; m_we = 0; s_gnt = 5'b00001;
        #1;
        n_checks++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL rd0_gnt: got %b want 1", m_gnt); end
        n_checks++; if (s_req !== 5'b00001) begin n_fail++; $display("FAIL rd0_sreq: got %b want 00001", s_req); end
        next_cycle();
        m_req = 0; s_gnt = '0;
        #1;
        n_checks++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd0_early: got %b want 0", m_rvalid); end
        next_cycle();
        s_rvalid = 5'b00001; rd[0] = 32'h1234_5678;
        #1;
        n_checks++; if (m_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd0_rvalid: got %b want 1", m_rvalid); end
        n_checks++; if (m_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd0_rdata: got %h want 12345678", m_rdata); end
        n_checks++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL rd0_err: got %b want 0", m_err); end
        next_cycle();
        s_rvalid = '0;
        #1;
        n_checks++; if (m_rvalid !== 1'b0 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL rd0_idle: got %b/%h want 0/0", m_rvalid, m_rdata); end
    endtask

    task automatic test_unmapped();
        m_req = 1; m_addr = 32'h5000_0000; s_gnt = 5'b11111;
        #1;
        n_checks++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL unm_gnt: got %b want 1", m_gnt); end
        n_checks++; if (s_req !== 5'b0) begin n_fail++; $display("FAIL unm_sreq: got %b want 0", s_req); end
        n_checks++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL unm_early: got %b want 0", m_rvalid); end
        next_cycle();
        m_req = 0; s_gnt = '0;
        #1;
        n_checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1) begin n_fail++; $display("FAIL unm_resp: got rv=%b err=%b want 1/1", m_rvalid, m_err); end
        n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unm_rdata: got %h want deadbeef", m_rdata); end
        next_cycle();
        #1;
        n_checks++; if (m_rvalid !== 1'b0 || m_err !== 1'b0) begin n_fail++; $display("FAIL unm_after: got rv=%b err=%b want 0/0", m_rvalid, m_err); end
    endtask

    task automatic test_back_to_back();
        m_req = 1; m_addr = 32'h0A00_0000; s_gnt = 5'b00101;
        #1;
        n_checks++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 1", m_gnt); end
        next_cycle();
        m_addr = 32'h0A00_0004;
        #1;
        n_checks++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt2: got %b want 1", m_gnt); end
        next_cycle();
        // FIFO full: a third slave-2 request is blocked even with a same-cycle pop.
        m_addr = 32'h0A00_0008; s_rvalid = 5'b00100; rd[2] = 32'hAAAA_0001;
        #1;
        n_checks++; if (m_gnt !== 1'b0 || s_req !== 5'b0) begin n_fail++; $display("FAIL b2b_full: got gnt=%b req=%b want 0/0", m_gnt, s_req); end
        n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_resp1: got %b/%h want 1/aaaa0001", m_rvalid, m_rdata); end
        next_cycle();
        m_addr = 32'h0000_0020; rd[2] = 32'hAAAA_0002;
        #1;
        n_checks++; if (m_gnt !== 1'b0 || s_req !== 5'b0) begin n_fail++; $display("FAIL b2b_stall: got gnt=%b req=%b want 0/0", m_gnt, s_req); end
        n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hAAAA_0002) begin n_fail++; $display("FAIL b2b_resp2: got %b/%h want 1/aaaa0002", m_rvalid, m_rdata); end
        next_cycle();
        s_rvalid = '0;
        #1;
        n_checks++; if (m_gnt !== 1'b1 || s_req !== 5'b00001) begin n_fail++; $display("FAIL b2b_s0gnt: got gnt=%b req=%b want 1/00001", m_gnt, s_req); end
        next_cycle();
        m_req = 0; s_gnt = '0; s_rvalid = 5'b00001; rd[0] = 32'h0000_0055;
        #1;
        n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h55) begin n_fail++; $display("FAIL b2b_s0resp: got %b/%h want 1/55", m_rvalid, m_rdata); end
        next_cycle();
        s_rvalid = '0;
    endtask

    task automatic test_timeout();
        m_req = 1; m_addr = 32'h0E00_0000; s_gnt = 5'b01000;
        #1;
        n_checks++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL to_gnt: got %b want 1", m_gnt); end
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            m_req = 0;
            #1;
            if (k < 8) begin
                n_checks++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got rvalid %b want 0", k, m_rvalid); end
            end else begin
                n_checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_fire: got %b/%b/%h want 1/1/deadbeef", m_rvalid, m_err, m_rdata); end
            end
        end
        next_cycle();
        m_req = 1; m_addr = 32'h0E00_0010; s_rvalid = 5'b01000; rd[3] = 32'h3333_3333;
        #1;
        n_checks++; if (m_gnt !== 1'b0 || s_req !== 5'b0) begin n_fail++; $display("FAIL to_drainstall: got gnt=%b req=%b want 0/0", m_gnt, s_req); end
        n_checks++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL to_dropped: got rvalid %b want 0", m_rvalid); end
        next_cycle();
        s_rvalid = '0;
        #1;
        n_checks++; if (m_gnt !== 1'b1 || s_req !== 5'b01000) begin n_fail++; $display("FAIL to_regnt: got gnt=%b req=%b want 1/01000", m_gnt, s_req); end
        next_cycle();
        m_req = 0; s_gnt = '0; s_rvalid = 5'b01000; rd[3] = 32'h4444_4444;
        #1;
        n_checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h4444_4444) begin n_fail++; $display("FAIL to_after: got %b/%b/%h want 1/0/44444444", m_rvalid, m_err, m_rdata); end
        next_cycle();
        s_rvalid = '0;
    endtask

    task automatic test_write();
        m_req = 1; m_addr = 32'h0F00_0004; m_we = 1; m_be = 4'b0011; m_wdata = 32'hCAFE_F00D;
        s_gnt = 5'b10000;
        #1;
        n_checks++; if (m_gnt !== 1'b1 || s_req !== 5'b10000) begin n_fail++; $display("FAIL wr_gnt: got gnt=%b req=%b want 1/10000", m_gnt, s_req); end
        n_checks++; if (s_be !== 4'b0011 || s_we !== 1'b1) begin n_fail++; $display("FAIL wr_be: got be=%b we=%b want 0011/1", s_be, s_we); end
        n_checks++; if (s_wdata !== 32'hCAFE_F00D || s_addr !== 32'h0F00_0004) begin n_fail++; $display("FAIL wr_data: got %h@%h want cafef00d@0f000004", s_wdata, s_addr); end
        next_cycle();
        m_req = 0; m_we = 0; m_be = 4'hF; s_gnt = '0; s_rvalid = 5'b10000;
        #1;
        n_checks++; if (m_rvalid !== 1'b1 || m_err !== 1'b0) begin n_fail++; $display("FAIL wr_resp: got rv=%b err=%b want 1/0", m_rvalid, m_err); end
        next_cycle();
        s_rvalid = '0;
    endtask

    task automatic test_reset_mid();
        m_req = 1; m_addr = 32'h0200_0000; s_gnt = 5'b00010;
        next_cycle();
        m_addr = 32'h0200_0004;
        next_cycle();
        #2 rst_ni = 0;
        #1;
        n_checks++; if (m_gnt !== 1'b0 || s_req !== 5'b0) begin n_fail++; $display("FAIL rst_gnt: got gnt=%b req=%b want 0/0", m_gnt, s_req); end
        n_checks++; if (m_rvalid !== 1'b0 || m_rdata !== 32'h0 || m_err !== 1'b0) begin n_fail++; $display("FAIL rst_out: got %b/%h/%b want 0/0/0", m_rvalid, m_rdata, m_err); end
        m_req = 0; s_gnt = '0;
        next_cycle();
        #2 rst_ni = 1;
        next_cycle();
        s_rvalid = 5'b00010; rd[1] = 32'h0BAD_0BAD;
        #1;
        n_checks++; if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_stale: got rvalid %b want 0", m_rvalid); end
        next_cycle();
        s_rvalid = '0; m_req = 1; m_addr = 32'h0200_0008; s_gnt = 5'b00010;
        #1;
        n_checks++; if (m_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_newgnt: got %b want 1", m_gnt); end
        next_cycle();
        m_req = 0; s_gnt = '0; s_rvalid = 5'b00010; rd[1] = 32'h1111_2222;
        #1;
        n_checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL rst_newresp: got %b/%h want 1/11112222", m_rvalid, m_rdata); end
        next_cycle();
        s_rvalid = '0;
    endtask

    initial begin
        test_reset();
        test_read_slave0();
        next_cycle();
        test_unmapped();
        next_cycle();
        test_back_to_back();
        test_timeout();
        test_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
